// File: rtl/legacy_chunk_deser_pkg.sv
// Shared state encodings and default geometry for the legacy chunk deserializer.
package legacy_chunk_deser_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } st_e;

  localparam int AW_DEF     = 4;
  localparam int NCHUNK_DEF = 4;
  localparam int CW_DEF     = 3;

endpackage

// File: rtl/legacy_chunk_deser_hold_reg.sv
// One-entry valid/ready holding register; it reloads in the same cycle it drains.
// Payload is stable while out_valid is high and out_ready is low.
module legacy_hold_reg #(
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          r_vld;
  logic [PW-1:0] r_dat;

  assign in_ready  = !r_vld || out_ready;
  assign out_valid = r_vld;
  assign out_data  = r_dat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (in_valid && in_ready) begin
      r_vld <= 1'b1;
      r_dat <= in_data;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/legacy_chunk_deser.sv
// Reassembles AW-bit chunks (LSB first) into WW-bit words, closed by NCHUNK beats or in_last.
// Output goes through a one-entry holding register; one cycle from completing beat to out_valid.
module legacy_chunk_deser
  import legacy_chunk_deser_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int NCHUNK = NCHUNK_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW*NCHUNK-1:0] out_data,
  output logic [CW-1:0]        out_cnt,
  output logic                 out_last
);

  localparam int WW = AW * NCHUNK;
  localparam int IW = $clog2(NCHUNK);
  localparam int PW = WW + CW + 1;

  st_e           r_st, w_st_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [WW-1:0] r_asm, w_asm_nxt, w_word;
  logic          w_hold_rdy, w_fire, w_end, w_done;
  logic [PW-1:0] w_pay_in, w_pay_out;

  // Ready never looks at in_valid/in_last, so upstream can rely on it combinationally.
  assign in_ready = rstn && !flush && w_hold_rdy;
  assign w_fire   = in_valid && in_ready;
  assign w_end    = in_last || (r_idx == IW'(NCHUNK - 1));
  assign w_done   = w_fire && w_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= ST_EMPTY;
    else       r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    if (flush)       w_st_nxt = ST_EMPTY;
    else if (w_fire) w_st_nxt = w_end ? ST_EMPTY : ST_FILL;
  end

  always_comb begin
    w_idx_nxt = r_idx;
    w_asm_nxt = r_asm;
    w_word    = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (k < int'(r_idx))       w_word[k*AW +: AW] = r_asm[k*AW +: AW];
      else if (k == int'(r_idx)) w_word[k*AW +: AW] = in_data;
    end
    if (flush || w_done) begin
      w_idx_nxt = '0;
      w_asm_nxt = '0;
    end else if (w_fire) begin
      w_idx_nxt = r_idx + IW'(1);
      w_asm_nxt = w_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
      r_asm <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_asm <= w_asm_nxt;
    end
  end

  assign w_pay_in = {w_word, CW'(r_idx) + CW'(1), in_last};

  legacy_hold_reg #(.PW(PW)) u_hold (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (w_done),
    .in_ready  (w_hold_rdy),
    .in_data   (w_pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_pay_out)
  );

  assign {out_data, out_cnt, out_last} = w_pay_out;

endmodule

// File: tb/tb_legacy_chunk_deser.sv
// Scoreboard bench for legacy_chunk_deser at AW=4, NCHUNK=4, CW=3.
module tb_legacy_chunk_deser;

  typedef struct packed {
    logic [15:0] dat;
    logic [2:0]  cnt;
    logic        lst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_last;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  legacy_chunk_deser #(.AW(4), .NCHUNK(4), .CW(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] c, input logic l);
    q.push_back({d, c, l});
  endtask

  task automatic send_beat(input logic [3:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("beat_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_dat"}, 32'(out_data), 32'd0);
    chk({tag, "_cnt"}, 32'(out_cnt), 32'd0);
    chk({tag, "_lst"}, 32'(out_last), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  // Mid-cycle async reset; everything in flight is discarded.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs(tag);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: hold stability while stalled, and scoreboard pops on every handshake.
  logic        hold_prev = 1'b0;
  logic [19:0] prev_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_vld", 32'(out_valid), 32'd1);
        chk("hold_word", 32'({out_data, out_cnt, out_last}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_word", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("word_dat", 32'(out_data), 32'(e.dat));
          chk("word_cnt", 32'(out_cnt), 32'(e.cnt));
          chk("word_lst", 32'(out_last), 32'(e.lst));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_data, out_cnt, out_last};
    end
  end

  initial begin
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;

    // Full word, back-to-back beats
    push(16'h4321, 3'd4, 1'b0);
    for (int i = 1; i <= 4; i++) send_beat(4'(i), 1'b0);
    chk("full_vld", 32'(out_valid), 32'd1);
    chk("full_dat", 32'(out_data), 32'h4321);
    @(posedge clk); #1;
    chk("full_vld_drop", 32'(out_valid), 32'd0);

    // Short word then full word: no residue
    push(16'h00BA, 3'd2, 1'b1);
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b1);
    push(16'h8765, 3'd4, 1'b0);
    for (int i = 5; i <= 8; i++) send_beat(4'(i), 1'b0);
    @(posedge clk); #1;

    // in_last on the final chunk still reports out_last
    push(16'h4321, 3'd4, 1'b1);
    for (int i = 1; i <= 4; i++) send_beat(4'(i), i == 4);
    @(posedge clk); #1;

    // Backpressure: first word held, second waits for the drain
    out_ready = 1'b0;
    push(16'h4321, 3'd4, 1'b0);
    push(16'h8765, 3'd4, 1'b0);
    fork
      begin
        for (int i = 1; i <= 8; i++) send_beat(4'(i), 1'b0);
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        repeat (4) begin
          @(negedge clk);
          chk("bp_rdy", 32'(in_ready), 32'd0);
          chk("bp_dat", 32'(out_data), 32'h4321);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_second_vld", 32'(out_valid), 32'd1);
    chk("bp_second_dat", 32'(out_data), 32'h8765);
    @(posedge clk); #1;

    // Streaming one-chunk words: one word per cycle, no gaps
    for (int v = 1; v <= 8; v++) begin
      push(16'(v), 3'd1, 1'b1);
      send_beat(4'(v), 1'b1);
      chk("strm_vld", 32'(out_valid), 32'd1);
      chk("strm_dat", 32'(out_data), 32'(v));
    end
    @(posedge clk); #1;
    chk("strm_end_vld", 32'(out_valid), 32'd0);

    // Flush drops partial word and refuses the same-cycle beat
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h9;
    @(negedge clk);
    chk("flush_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    push(16'h6543, 3'd4, 1'b0);
    for (int i = 3; i <= 6; i++) send_beat(4'(i), 1'b0);
    @(posedge clk); #1;

    // Async reset with a word pending in the holding register
    out_ready = 1'b0;
    send_beat(4'h7, 1'b1);
    chk("pend_vld", 32'(out_valid), 32'd1);
    async_reset("rst_pend");

    // Async reset mid-word, then a clean word
    out_ready = 1'b1;
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    async_reset("rst_mid");
    chk("post_rst_vld", 32'(out_valid), 32'd0);
    push(16'hFEDC, 3'd4, 1'b0);
    for (int i = 12; i <= 15; i++) send_beat(4'(i), 1'b0);
    chk("post_rst_dat", 32'(out_data), 32'hFEDC);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
